// File: rtl/fast_pkt_pkg.sv
// Shared definitions for the fast packet path: line format, port indices and
// the arbiter state encoding used by the return-path merger.
package fast_pkt_pkg;

  localparam int LINE_W    = 134;
  localparam int NUM_PORTS = 3;

  localparam logic [1:0] LT_HEAD = 2'b01;
  localparam logic [1:0] LT_BODY = 2'b11;
  localparam logic [1:0] LT_TAIL = 2'b10;

  localparam logic [1:0] PORT_PGM = 2'd0;
  localparam logic [1:0] PORT_LCM = 2'd1;
  localparam logic [1:0] PORT_SSM = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  typedef logic [LINE_W-1:0] line_t;

  function automatic logic [1:0] line_type(input line_t line);
    return line[LINE_W-1:LINE_W-2];
  endfunction

  // Round-robin successor over the three requesters.
  function automatic logic [1:0] port_next(input logic [1:0] port);
    return (port == PORT_SSM) ? PORT_PGM : (port + 2'd1);
  endfunction

endpackage

// File: rtl/umux_pkt_fifo.sv
// Single-clock show-ahead line buffer: dout_o presents the oldest line whenever
// the buffer is not empty. Writes to a full buffer and reads of an empty one are ignored.
module umux_pkt_fifo
  import fast_pkt_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          wr_i,
  input  line_t         din_i,
  input  logic          rd_i,
  output line_t         dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   free_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  line_t           mem_q [2**AW];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            wr_en_s;
  logic            rd_en_s;

  assign full_o  = (cnt_q == DEPTH);
  assign empty_o = (cnt_q == {(AW+1){1'b0}});
  assign free_o  = DEPTH - cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign wr_en_s = wr_i && !full_o;
  assign rd_en_s = rd_i && !empty_o;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else if (clr_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(wr_en_s) - (AW+1)'(rd_en_s);
    end
  end

endmodule

// File: rtl/umux_arb.sv
// Return-path packet merger: PGM, LCM and SSM streams are buffered per port and
// forwarded whole, one complete packet at a time, in round-robin order.
module umux_arb
  import fast_pkt_pkg::*;
#(
  parameter int FIFO_AW       = 8,
  parameter int MAX_PKT_LINES = 98
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LINE_W-1:0]    pgm_data,
  input  logic                 pgm_data_wr,
  input  logic                 pgm_data_valid,
  input  logic                 pgm_data_valid_wr,
  output logic                 pgm_data_ready,
  input  logic [LINE_W-1:0]    lcm_data,
  input  logic                 lcm_data_wr,
  input  logic                 lcm_data_valid,
  input  logic                 lcm_data_valid_wr,
  output logic                 lcm_data_ready,
  input  logic [LINE_W-1:0]    ssm_data,
  input  logic                 ssm_data_wr,
  input  logic                 ssm_data_valid,
  input  logic                 ssm_data_valid_wr,
  output logic                 ssm_data_ready,
  output logic [LINE_W-1:0]    pktout_data,
  output logic                 pktout_data_wr,
  output logic                 pktout_data_valid,
  output logic                 pktout_data_valid_wr,
  input  logic                 pktout_data_ready,
  output logic [NUM_PORTS-1:0] ovf_err
);

  localparam int CW = FIFO_AW + 1;

  line_t                in_data_s   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_wr_s;
  logic [NUM_PORTS-1:0] in_valid_s;
  logic [NUM_PORTS-1:0] in_valid_wr_s;
  line_t                fifo_dout_s [NUM_PORTS];
  logic [CW-1:0]        fifo_free_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full_s;
  logic [NUM_PORTS-1:0] fifo_empty_s;
  logic [NUM_PORTS-1:0] rd_en_s;
  logic                 clr_s;

  arb_state_e           state_q;
  logic [1:0]           grant_q;
  logic [1:0]           rr_ptr_q;
  logic [CW-1:0]        pkt_cnt_q [NUM_PORTS];
  logic [CW-1:0]        pkt_cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] ready_q;
  logic [NUM_PORTS-1:0] ovf_q;
  line_t                out_data_q;
  logic                 out_wr_q;
  logic                 out_valid_q;

  logic [NUM_PORTS-1:0] cnt_inc_s;
  logic [NUM_PORTS-1:0] cnt_dec_s;
  logic [NUM_PORTS-1:0] pkt_avail_s;
  line_t                sel_line_s;
  logic                 sel_rd_s;
  logic                 sel_tail_s;
  logic                 any_avail_s;
  logic [1:0]           cand1_s;
  logic [1:0]           cand2_s;
  logic [1:0]           pick_s;

  assign in_data_s[0]     = pgm_data;
  assign in_data_s[1]     = lcm_data;
  assign in_data_s[2]     = ssm_data;
  assign in_wr_s          = {ssm_data_wr, lcm_data_wr, pgm_data_wr};
  assign in_valid_s       = {ssm_data_valid, lcm_data_valid, pgm_data_valid};
  assign in_valid_wr_s    = {ssm_data_valid_wr, lcm_data_valid_wr, pgm_data_valid_wr};
  assign clr_s            = !rst_n;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    umux_pkt_fifo #(
      .AW (FIFO_AW)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr_s),
      .wr_i    (in_wr_s[g]),
      .din_i   (in_data_s[g]),
      .rd_i    (rd_en_s[g]),
      .dout_o  (fifo_dout_s[g]),
      .full_o  (fifo_full_s[g]),
      .empty_o (fifo_empty_s[g]),
      .free_o  (fifo_free_s[g])
    );
  end

  // A packet only counts once its tail actually lands in the buffer with valid set.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_inc_s[i]   = in_wr_s[i] && !fifo_full_s[i] &&
                       (line_type(in_data_s[i]) == LT_TAIL) &&
                       in_valid_wr_s[i] && in_valid_s[i];
      rd_en_s[i]     = (state_q == ST_SEND) && (grant_q == 2'(i)) && !fifo_empty_s[i];
      pkt_avail_s[i] = (pkt_cnt_q[i] != {CW{1'b0}});
    end
  end

  // Egress line selection and per-port packet count update.
  always_comb begin
    sel_line_s = fifo_dout_s[grant_q];
    sel_rd_s   = |rd_en_s;
    sel_tail_s = sel_rd_s && (line_type(sel_line_s) == LT_TAIL);
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_dec_s[i] = sel_tail_s && (grant_q == 2'(i)) && pkt_avail_s[i];
      pkt_cnt_d[i] = pkt_cnt_q[i] + CW'(cnt_inc_s[i]) - CW'(cnt_dec_s[i]);
    end
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    cand1_s     = port_next(rr_ptr_q);
    cand2_s     = port_next(cand1_s);
    any_avail_s = |pkt_avail_s;
    if (pkt_avail_s[rr_ptr_q]) begin
      pick_s = rr_ptr_q;
    end else if (pkt_avail_s[cand1_s]) begin
      pick_s = cand1_s;
    end else begin
      pick_s = cand2_s;
    end
  end

  // Arbiter FSM with registered output line and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= PORT_PGM;
      rr_ptr_q    <= PORT_PGM;
      out_data_q  <= {LINE_W{1'b0}};
      out_wr_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= sel_rd_s ? sel_line_s : {LINE_W{1'b0}};
      out_wr_q    <= sel_rd_s;
      out_valid_q <= sel_tail_s;
      case (state_q)
        ST_IDLE: begin
          if (pktout_data_ready && any_avail_s) begin
            grant_q <= pick_s;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Downstream ready is not consulted here: a started packet always finishes.
          if (sel_tail_s) begin
            rr_ptr_q <= port_next(grant_q);
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Packet counts, sticky overflow flags and per-port ready from the fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= {CW{1'b0}};
      end
      ready_q <= {NUM_PORTS{1'b1}};
      ovf_q   <= {NUM_PORTS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= pkt_cnt_d[i];
        ready_q[i]   <= (32'(fifo_free_s[i]) >= 32'(MAX_PKT_LINES));
      end
      ovf_q <= ovf_q | (in_wr_s & fifo_full_s);
    end
  end

  assign pgm_data_ready       = ready_q[0];
  assign lcm_data_ready       = ready_q[1];
  assign ssm_data_ready       = ready_q[2];
  assign pktout_data          = out_data_q;
  assign pktout_data_wr       = out_wr_q;
  assign pktout_data_valid    = out_valid_q;
  assign pktout_data_valid_wr = out_valid_q;
  assign ovf_err              = ovf_q;

endmodule
